// File: rtl/gray_bcd_scanner.sv
// Gray-code switches -> binary LEDs -> double-dabble BCD -> multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the units digit.
module gray_bcd_scanner #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  gray_code,
  output logic [WIDTH-1:0]  leds,
  output logic [6:0]        display_code,
  output logic [DIGITS-1:0] anodes,
  output logic              busy
);

  function automatic int unsigned dec_digits(int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'd10;
      end
    end
    return n;
  endfunction

  localparam int unsigned NeedDigits = dec_digits(WIDTH);
  localparam int unsigned BcdW       = 4 * DIGITS;
  localparam int unsigned SrW        = BcdW + WIDTH;
  localparam int unsigned CntW       = $clog2(WIDTH + 1);
  localparam int unsigned ScanW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gray_bcd_scanner: WIDTH must be 2..16");
  end
  if (DIGITS < NeedDigits) begin : g_bad_digits
    $error("gray_bcd_scanner: DIGITS too small for WIDTH");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("gray_bcd_scanner: REFRESH_DIV must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [WIDTH-1:0] sync1, sync2, bin_next, last_bin;
  logic [SrW-1:0]   sr, sr_adj;
  logic [BcdW-1:0]  bcd_disp;
  logic [CntW-1:0]  shift_cnt;
  state_e           state;
  logic [ScanW-1:0] scan_cnt;
  logic [IdxW-1:0]  idx, idx_next;
  logic [3:0]       sel_nib;
  logic [6:0]       seg_next;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_next[i] = ^(sync2 >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      leds  <= '0;
    end else begin
      sync1 <= gray_code;
      sync2 <= sync1;
      leds  <= bin_next;
    end
  end

  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (sr[WIDTH+4*k +: 4] >= 4'd5) sr_adj[WIDTH+4*k +: 4] = sr[WIDTH+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      last_bin  <= '0;
      sr        <= '0;
      bcd_disp  <= '0;
      shift_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (leds != last_bin) begin
            state <= StLoad;
            busy  <= 1'b1;
          end
        end
        StLoad: begin
          sr        <= {{BcdW{1'b0}}, leds};
          last_bin  <= leds;
          shift_cnt <= '0;
          state     <= StShift;
        end
        StShift: begin
          sr        <= sr_adj << 1;
          shift_cnt <= shift_cnt + 1'b1;
          if (shift_cnt == CntW'(WIDTH - 1)) state <= StDone;
        end
        StDone: begin
          bcd_disp <= sr[SrW-1 -: BcdW];
          state    <= StIdle;
          busy     <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    idx_next = idx;
    if (scan_cnt == ScanW'(REFRESH_DIV - 1)) begin
      idx_next = (idx == IdxW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    sel_nib = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_next == IdxW'(k)) sel_nib = bcd_disp[4*k +: 4];
    end
  end

  function automatic logic [6:0] seg_decode(logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero;
  logic              sel_upper_zero;

  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      acc           = acc & (bcd_disp[4*k +: 4] == 4'd0);
      upper_zero[k] = acc;
    end
    sel_upper_zero = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_next == IdxW'(k)) sel_upper_zero = upper_zero[k];
    end
  end

  always_comb begin
    seg_next = seg_decode(sel_nib);
    if (idx_next != '0 && sel_upper_zero) seg_next = 7'b1111111;
  end
`else
  always_comb begin
    seg_next = seg_decode(sel_nib);
  end
`endif

  // Anodes and segments are both registered from idx_next so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt     <= '0;
      idx          <= '0;
      anodes       <= ~DIGITS'(1);
      display_code <= 7'b1000000;
    end else begin
      scan_cnt     <= (scan_cnt == ScanW'(REFRESH_DIV - 1)) ? '0 : scan_cnt + 1'b1;
      idx          <= idx_next;
      anodes       <= ~(DIGITS'(1) << idx_next);
      display_code <= seg_next;
    end
  end

endmodule

// File: tb/tb_gray_bcd_scanner.sv
// Self-checking bench for gray_bcd_scanner (WIDTH=8, DIGITS=3, REFRESH_DIV=4).
module tb_gray_bcd_scanner;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gray = '0;
  logic [7:0] leds;
  logic [6:0] display_code;
  logic [2:0] anodes;
  logic       busy;

  int checks = 0;
  int errors = 0;

  gray_bcd_scanner #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .gray_code    (gray),
    .leds         (leds),
    .display_code (display_code),
    .anodes       (anodes),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  gray;
    int unsigned bin;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs [8];
  logic [6:0] seg_tab [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned gray2bin(input logic [7:0] g);
    int unsigned b;
    b = 0;
    for (int i = 0; i < 8; i++) b = b ^ (int'(g) >> i);
    return b;
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] bcd, input int k);
    int unsigned above;
    above = int'(bcd) >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && above == 0) return 7'b1111111;
`endif
    return seg_tab[above % 16];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Watch the scan for several rotations, checking order, slot length and digit content.
  task automatic scan_check(input logic [11:0] bcd);
    logic [2:0] prev;
    int         run, changes, k, pk;
    prev    = anodes;
    run     = 1;
    changes = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      case (anodes)
        3'b110:  k = 0;
        3'b101:  k = 1;
        3'b011:  k = 2;
        default: k = -1;
      endcase
      chk("anode_valid", 32'(k >= 0), 32'd1);
      if (k >= 0) chk($sformatf("seg_digit%0d", k), 32'(display_code), 32'(exp_seg(bcd, k)));
      if (anodes == prev) begin
        run++;
      end else begin
        case (prev)
          3'b110:  pk = 0;
          3'b101:  pk = 1;
          default: pk = 2;
        endcase
        chk("anode_order", 32'(k), 32'((pk + 1) % 3));
        if (changes > 0) chk("slot_len", 32'(run), 32'd4);
        changes++;
        run = 1;
      end
      prev = anodes;
    end
  endtask

  initial begin
    logic [11:0] seen [$];
    logic [11:0] last;
    int          n;
    logic [7:0]  g2;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{8'h80, 255, 12'h255};
    vecs[1] = '{8'h0D, 9,   12'h009};
    vecs[2] = '{8'h56, 100, 12'h100};
    vecs[3] = '{8'h01, 1,   12'h001};
    vecs[4] = '{8'hC0, 128, 12'h128};
    vecs[5] = '{8'h37, 37,  12'h037};
    vecs[6] = '{8'hAC, 200, 12'h200};
    vecs[7] = '{8'h00, 0,   12'h000};

    // Reset state
    rst = 1'b1;
    gray = 8'h5A;
    for (int i = 0; i < 3; i++) step();
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_anodes", 32'(anodes), 32'b110);
    chk("rst_seg", 32'(display_code), 32'b1000000);
    chk("rst_bcd", 32'(dut.bcd_disp), 32'd0);
    gray = 8'h00;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_no_conv", 32'(busy), 32'd0);

    // Latency of leds, busy and the display register for 8'h80
    gray = 8'h80;
    for (int e = 0; e < 16; e++) begin
      step();
      chk($sformatf("lat_leds_e%0d", e), 32'(leds), (e >= 2) ? 32'hFF : 32'h0);
      chk($sformatf("lat_busy_e%0d", e), 32'(busy), 32'(e >= 3 && e <= W + 4));
      chk($sformatf("lat_bcd_e%0d", e), 32'(dut.bcd_disp), (e >= W + 5) ? 32'h255 : 32'h0);
    end

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      gray = vecs[v].gray;
      for (int i = 0; i < 40; i++) step();
      chk($sformatf("vec%0d_leds", v), 32'(leds), vecs[v].bin);
      chk($sformatf("vec%0d_bcd", v), 32'(dut.bcd_disp), 32'(vecs[v].bcd));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      scan_check(vecs[v].bcd);
    end

    // Input change on the 3rd SHIFT cycle: 255 shows first, then 1
    gray = 8'h00;
    do_reset();
    step();
    gray = 8'h80;
    for (int e = 0; e < 7; e++) step();
    gray = 8'h01;
    last = dut.bcd_disp;
    for (int i = 0; i < 60; i++) begin
      step();
      if (dut.bcd_disp != last) begin
        seen.push_back(dut.bcd_disp);
        last = dut.bcd_disp;
      end
    end
    chk("mid_change_count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 1) chk("mid_change_first", 32'(seen[0]), 32'h255);
    if (seen.size() >= 2) chk("mid_change_final", 32'(seen[1]), 32'h001);
    chk("mid_change_leds", 32'(leds), 32'd1);
    scan_check(12'h001);

    // Reset pulse during SHIFT aborts, then the conversion restarts
    gray = 8'h00;
    do_reset();
    step();
    gray = 8'h80;
    for (int e = 0; e < 6; e++) step();
    rst = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(dut.bcd_disp), 32'd0);
    rst = 1'b0;
    n = 0;
    while (n < 30 && dut.bcd_disp != 12'h255) begin
      step();
      n++;
    end
    chk("restart_within", 32'(n >= 1 && n <= W + 7), 32'd1);
    chk("restart_bcd", 32'(dut.bcd_disp), 32'h255);

    // Random pairs of inputs, second arriving at a random point
    for (int r = 0; r < 25; r++) begin
      gray = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 16);
      for (int i = 0; i < n; i++) step();
      g2 = 8'($urandom_range(0, 255));
      gray = g2;
      for (int i = 0; i < 50; i++) step();
      chk($sformatf("rnd%0d_leds", r), 32'(leds), gray2bin(g2));
      chk($sformatf("rnd%0d_bcd", r), 32'(dut.bcd_disp), 32'(to_bcd(gray2bin(g2))));
      chk($sformatf("rnd%0d_busy", r), 32'(busy), 32'd0);
      if (r % 6 == 0) scan_check(to_bcd(gray2bin(g2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
